nrisc_int_ctrl: RTL
===================

NRISC_INT_CTRL -- requirements
Module: nrisc_int_ctrl

Interface
REQ-001 The block SHALL have parameter CH_BASE, default 8'h00, meaning the INTERRUPT_ch value reported for source 0.
REQ-002 The block SHALL have parameter N_SRC, default 8, meaning the number of interrupt sources; the legal range is 1..8.
REQ-003 clk  input  1  main clock; all flops SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset; it is asynchronous and active-high.
REQ-005 INT_req  input  N_SRC  raw asynchronous interrupt request lines; a rising edge on a line is a request.
REQ-006 INT_en_wr  input  1  enable-register write strobe.
REQ-007 INT_en_data  input  N_SRC  enable-register write data; bit=1 enables that source.
REQ-008 INT_ack  input  1  single-cycle pulse from the core: the interrupt has been taken.
REQ-009 INT_eoi  input  1  single-cycle pulse from the core: the ISR has returned.
REQ-010 INTERRUPT_flag  output  1  interrupt request to the core.
REQ-011 INTERRUPT_ch  output  8  channel number of the presented interrupt.
REQ-012 INT_pending  output  N_SRC  latched pending bits, unmasked.
REQ-013 INT_busy  output  1  high while in SERVICE state.

Function
REQ-014 Each INT_req bit SHALL pass through a 2-flop synchronizer, followed by a third flop for edge detection.
REQ-015 A pending bit SHALL set on the clock edge after the synchronized 0->1 transition is detected. This is the 3rd rising clk edge after INT_req rises, for an input that is stable over that edge.
REQ-016 Pending bits SHALL NOT count: a second edge on an already-pending source SHALL leave a single pending bit.
REQ-017 The enable register SHALL load INT_en_data on the clock edge where INT_en_wr=1. Disabled sources SHALL still latch pending, but SHALL NOT be selected.
REQ-018 Selection SHALL be fixed priority, with the lowest index highest, among (pending & enable).
REQ-019 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-020 IDLE -> REQ SHALL occur on the clock edge where any (pending & enable) bit is 1. On that edge the winning index SHALL be latched into sel_idx, and INTERRUPT_ch SHALL be set to CH_BASE+sel_idx (8-bit, wrap-around modulo 256).
REQ-021 In REQ, INTERRUPT_flag SHALL be 1 and INTERRUPT_ch SHALL be held stable, even if a higher-priority source becomes pending.
REQ-022 REQ -> SERVICE SHALL occur on INT_ack=1. On the same edge: pending[sel_idx] SHALL clear, and INTERRUPT_flag SHALL go to 0.
REQ-023 If a new synchronized edge on sel_idx arrives in the same cycle as INT_ack, the set SHALL win and pending[sel_idx] SHALL remain 1.
REQ-024 If enable[sel_idx] becomes 0 while in REQ, with no INT_ack in that cycle, the FSM SHALL return to IDLE with flag=0 (withdrawal). The pending bit SHALL be kept.
REQ-025 If INT_ack and the disabling write occur in the same cycle, INT_ack SHALL win.
REQ-026 In SERVICE, no new interrupt SHALL be presented (no nesting). INTERRUPT_ch SHALL hold the last value, and INT_busy SHALL be 1.
REQ-027 SERVICE -> IDLE SHALL occur on INT_eoi=1. The next interrupt, if pending, SHALL be presented with flag=1 on the following edge.
REQ-028 INT_ack outside REQ SHALL be ignored, and INT_eoi outside SERVICE SHALL be ignored.
REQ-029 The minimum latency from an INT_req rise to INTERRUPT_flag=1 SHALL be 4 rising clk edges, with the FSM in IDLE and the source enabled.

Reset
REQ-030 Asserting rst SHALL immediately, without waiting for clk, force the following values:
- state=IDLE
- INTERRUPT_flag=0
- INTERRUPT_ch=8'h00
- INT_pending=0
- INT_busy=0
- enable=0
- all synchronizer flops=0
REQ-031 rst asserted mid-REQ or mid-SERVICE SHALL discard the in-flight interrupt with no residual pending state.
REQ-032 After rst deasserts, a line held high SHALL NOT generate a request until it goes low and then high again.

Verification
REQ-033 Enable register = 8'hFF, INT_req[3] rises -> INTERRUPT_flag=1 and INTERRUPT_ch=8'h03 after edge 4; ack -> flag=0 and INT_busy=1; eoi -> INT_busy=0.
REQ-034 INT_req[5] and INT_req[2] rise in the same cycle -> ch=8'h02 first. After ack+eoi: ch=8'h05, flag=1 on the edge after eoi.
REQ-035 Enable=8'h00, INT_req[1] rises -> INT_pending=8'h02 and flag stays 0. Write enable=8'h02 -> flag=1 and ch=8'h01 on the next edge.
REQ-036 In REQ with ch=8'h04, write enable=8'h00 -> flag=0, state=IDLE, and INT_pending[4] stays 1.
REQ-037 CH_BASE=8'hFC, source 6 -> INTERRUPT_ch=8'h02 (wrap). A new edge on source 6 coincident with ack -> pending[6] remains 1.
REQ-038 rst pulsed while in SERVICE with INT_pending=8'h81 -> all outputs are at their reset values before the next clk edge, and no interrupt is presented afterwards without new edges.

Source files
------------

// File: rtl/nrisc_int_ctrl.sv
// Fixed-priority interrupt controller: per-source synchronizer + edge detect,
// sticky pending bits, enable mask, and an IDLE/REQ/SERVICE handshake with the core.
module nrisc_int_ctrl #(
  parameter logic [7:0] CH_BASE = 8'h00,
  parameter int         N_SRC   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] INT_req,
  input  logic             INT_en_wr,
  input  logic [N_SRC-1:0] INT_en_data,
  input  logic             INT_ack,
  input  logic             INT_eoi,
  output logic             INTERRUPT_flag,
  output logic [7:0]       INTERRUPT_ch,
  output logic [N_SRC-1:0] INT_pending,
  output logic             INT_busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   sync1_q, sync1_d;
  logic [N_SRC-1:0]   sync2_q, sync2_d;
  logic [N_SRC-1:0]   sync3_q, sync3_d;
  logic [1:0]         settle_q, settle_d;
  logic [N_SRC-1:0]   en_q, en_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [2:0]         sel_q, sel_d;
  logic               flag_q, flag_d;
  logic [7:0]         ch_q, ch_d;
  logic               busy_q, busy_d;

  logic               settled;
  logic [N_SRC-1:0]   rise;
  logic [7:0]         cand8, en8, clr8;
  logic [2:0]         win_idx;
  logic               win_any;

  always_comb begin
    sync1_d = INT_req;
    sync2_d = sync1_q;
    sync3_d = sync2_q;

    // Edge detection is held off until the third flop holds a real sample,
    // so a line already high when reset releases is not taken as a new edge.
    settled  = (settle_q == 2'd3);
    settle_d = settled ? settle_q : settle_q + 2'd1;
    rise     = sync2_q & ~sync3_q & {N_SRC{settled}};

    en_d = INT_en_wr ? INT_en_data : en_q;

    cand8 = '0;
    cand8[N_SRC-1:0] = pending_q & en_q;
    en8 = '0;
    en8[N_SRC-1:0] = en_d;

    win_any = |cand8;
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand8[i]) win_idx = 3'(i);
    end

    clr8    = '0;
    state_d = state_q;
    sel_d   = sel_q;
    flag_d  = flag_q;
    ch_d    = ch_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = REQ;
          sel_d   = win_idx;
          flag_d  = 1'b1;
          ch_d    = CH_BASE + {5'd0, win_idx};
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a same-cycle disabling write.
        if (INT_ack) begin
          state_d     = SERVICE;
          clr8[sel_q] = 1'b1;
          flag_d      = 1'b0;
          busy_d      = 1'b1;
        end else if (!en8[sel_q]) begin
          state_d = IDLE;
          flag_d  = 1'b0;
        end
      end
      SERVICE: begin
        if (INT_eoi) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        flag_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A fresh edge in the acknowledge cycle re-arms the source.
    pending_d = (pending_q & ~clr8[N_SRC-1:0]) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      settle_q  <= 2'd0;
      en_q      <= '0;
      pending_q <= '0;
      sel_q     <= 3'd0;
      flag_q    <= 1'b0;
      ch_q      <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      settle_q  <= settle_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      flag_q    <= flag_d;
      ch_q      <= ch_d;
      busy_q    <= busy_d;
    end
  end

  assign INTERRUPT_flag = flag_q;
  assign INTERRUPT_ch   = ch_q;
  assign INT_pending    = pending_q;
  assign INT_busy       = busy_q;

endmodule
